// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one combinational ALU between two requesters.
// Requests are granted round-robin. The winning operands are registered into
// the ALU. The ALU outputs are captured one cycle later and returned to the
// winner over a valid/ready response handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; ready is offered to the granted port
// EXEC  | ALU evaluates the registered operands; outputs captured at edge
// RESP  | captured result presented to the owner until it takes it
module alu_rr_arbiter #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [n-1:0] req0_A,
    input  logic [n-1:0] req0_B,
    input  logic [2:0]   req0_ALUctr,
    output logic         resp0_valid,
    input  logic         resp0_ready,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [n-1:0] req1_A,
    input  logic [n-1:0] req1_B,
    input  logic [2:0]   req1_ALUctr,
    output logic         resp1_valid,
    input  logic         resp1_ready,

    output logic [n-1:0] resp_Result,
    output logic         resp_Zero,
    output logic         resp_Overflow,

    output logic [n-1:0] alu_A,
    output logic [n-1:0] alu_B,
    output logic [2:0]   alu_ctr,
    input  logic [n-1:0] alu_Result,
    input  logic         alu_Zero,
    input  logic         alu_Overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // last_grant = 1 after reset so port 0 wins the first contention.
    logic last_grant;
    logic owner;
    logic grant0;
    logic grant1;
    logic accept;

    // Round-robin pick: a lone requester wins, otherwise the port that did not win last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (last_grant) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else if (req0_valid) begin
            grant0 = 1'b1;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt   = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp0_valid = ~owner;
                resp1_valid = owner;
                // The non-owner's resp_ready is deliberately not looked at.
                if (owner ? resp1_ready : resp0_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept = (state == IDLE) && (grant0 || grant1);

    // Operand latch at the request handshake; ALU inputs hold their last value otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_A      <= '0;
            alu_B      <= '0;
            alu_ctr    <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            alu_A      <= grant1 ? req1_A      : req0_A;
            alu_B      <= grant1 ? req1_B      : req0_B;
            alu_ctr    <= grant1 ? req1_ALUctr : req0_ALUctr;
            owner      <= grant1;
            last_grant <= grant1;
        end
    end

    // Capture the ALU outputs at the edge that closes EXEC; held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_Result   <= '0;
            resp_Zero     <= 1'b0;
            resp_Overflow <= 1'b0;
        end else if (state == EXEC) begin
            resp_Result   <= alu_Result;
            resp_Zero     <= alu_Zero;
            resp_Overflow <= alu_Overflow;
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Testbench for alu_rr_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_alu_rr_arbiter;

    localparam logic [2:0] C_AND = 3'b000;
    localparam logic [2:0] C_OR  = 3'b001;
    localparam logic [2:0] C_ADD = 3'b010;
    localparam logic [2:0] C_SUB = 3'b110;
    localparam logic [2:0] C_SLT = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
    logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
    logic [31:0] req0_A, req0_B, req1_A, req1_B;
    logic [2:0]  req0_ALUctr, req1_ALUctr;
    logic [31:0] resp_Result;
    logic        resp_Zero, resp_Overflow;
    logic [31:0] alu_A, alu_B, alu_Result;
    logic [2:0]  alu_ctr;
    logic        alu_Zero, alu_Overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: returns {Overflow, Zero, Result}.
    function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c);
        logic [31:0] r;
        logic        o;
        o = 1'b0;
        case (c)
            C_ADD: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            C_SUB: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            C_AND: r = a & b;
            C_OR:  r = a | b;
            C_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = a ^ b;
        endcase
        return {o, (r == 32'd0), r};
    endfunction

    assign {alu_Overflow, alu_Zero, alu_Result} = alu_ref(alu_A, alu_B, alu_ctr);

    alu_rr_arbiter #(.n(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
        .req0_ALUctr(req0_ALUctr), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
        .req1_ALUctr(req1_ALUctr), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_Result(resp_Result), .resp_Zero(resp_Zero), .resp_Overflow(resp_Overflow),
        .alu_A(alu_A), .alu_B(alu_B), .alu_ctr(alu_ctr),
        .alu_Result(alu_Result), .alu_Zero(alu_Zero), .alu_Overflow(alu_Overflow)
    );

    task automatic apply_reset;
        rst_n = 1'b0;
        req0_valid = 0; req0_A = 0; req0_B = 0; req0_ALUctr = 0; resp0_ready = 0;
        req1_valid = 0; req1_A = 0; req1_B = 0; req1_ALUctr = 0; resp1_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset;
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_req0_ready got %0b exp 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_req1_ready got %0b exp 0", req1_ready); end
        checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL rst_resp0_valid got %0b exp 0", resp0_valid); end
        checks++; if (resp1_valid !== 1'b0) begin errors++; $display("FAIL rst_resp1_valid got %0b exp 0", resp1_valid); end
        checks++; if ({alu_A, alu_B, alu_ctr} !== 67'd0) begin errors++; $display("FAIL rst_alu_in got %h/%h/%0d exp 0", alu_A, alu_B, alu_ctr); end
        checks++; if ({resp_Result, resp_Zero, resp_Overflow} !== 34'd0) begin errors++; $display("FAIL rst_resp got %h/%0b/%0b exp 0", resp_Result, resp_Zero, resp_Overflow); end
    endtask

    task automatic test_single_add;
        apply_reset;
        req0_valid = 1; req0_A = 32'h5; req0_B = 32'h3; req0_ALUctr = C_ADD;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL t1_req0_ready got %0b exp 1", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL t1_req1_ready got %0b exp 0", req1_ready); end
        @(negedge clk); req0_valid = 0; #1;
        checks++; if (alu_A !== 32'h5 || alu_B !== 32'h3 || alu_ctr !== C_ADD) begin errors++; $display("FAIL t1_alu_in got %h/%h/%0d exp 5/3/%0d", alu_A, alu_B, alu_ctr, C_ADD); end
        checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL t1_resp0_early got %0b exp 0", resp0_valid); end
        @(negedge clk); #1;
        checks++; if (resp0_valid !== 1'b1) begin errors++; $display("FAIL t1_resp0_valid got %0b exp 1", resp0_valid); end
        checks++; if (resp1_valid !== 1'b0) begin errors++; $display("FAIL t1_resp1_valid got %0b exp 0", resp1_valid); end
        checks++; if (resp_Result !== 32'd8 || resp_Zero !== 1'b0 || resp_Overflow !== 1'b0) begin errors++; $display("FAIL t1_result got %h/%0b/%0b exp 8/0/0", resp_Result, resp_Zero, resp_Overflow); end
        resp0_ready = 1;
        @(negedge clk); resp0_ready = 0; #1;
        checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL t1_resp0_done got %0b exp 0", resp0_valid); end
        checks++; if (alu_A !== 32'h5) begin errors++; $display("FAIL t1_alu_hold got %h exp 5", alu_A); end
    endtask

    task automatic test_round_robin;
        int c;
        apply_reset;
        req0_valid = 1; req0_A = 1; req0_B = 1; req0_ALUctr = C_SUB;
        req1_valid = 1; req1_A = 7; req1_B = 7; req1_ALUctr = C_SUB;
        resp0_ready = 1; resp1_ready = 1;
        #1;
        for (int k = 0; k < 4; k++) begin
            c = 0;
            while (!(req0_ready || req1_ready) && c < 8) begin @(negedge clk); #1; c++; end
            checks++; if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin errors++; $display("FAIL rr_grant%0d got %0b%0b exp port %0d", k, req1_ready, req0_ready, k % 2); end
            @(negedge clk); #1;
            @(negedge clk); #1;
            checks++; if (resp0_valid !== (k % 2 == 0) || resp1_valid !== (k % 2 == 1)) begin errors++; $display("FAIL rr_resp%0d got %0b%0b exp port %0d", k, resp1_valid, resp0_valid, k % 2); end
            checks++; if (resp_Result !== 32'd0 || resp_Zero !== 1'b1) begin errors++; $display("FAIL rr_result%0d got %h/%0b exp 0/1", k, resp_Result, resp_Zero); end
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_overflow;
        apply_reset;
        req1_valid = 1; req1_A = 32'h7FFF_FFFF; req1_B = 32'h1; req1_ALUctr = C_ADD;
        @(negedge clk); req1_valid = 0;
        @(negedge clk); #1;
        checks++; if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0) begin errors++; $display("FAIL ovf_valid got %0b%0b exp 10", resp1_valid, resp0_valid); end
        checks++; if (resp_Result !== 32'h8000_0000 || resp_Overflow !== 1'b1 || resp_Zero !== 1'b0) begin errors++; $display("FAIL ovf_result got %h/%0b/%0b exp 80000000/1/0", resp_Result, resp_Overflow, resp_Zero); end
        resp1_ready = 1;
        @(negedge clk); resp1_ready = 0;
    endtask

    task automatic test_backpressure;
        apply_reset;
        req0_valid = 1; req0_A = 32'd100; req0_B = 32'd23; req0_ALUctr = C_ADD;
        req1_valid = 1; req1_A = 32'd1;   req1_B = 32'd2;  req1_ALUctr = C_ADD;
        resp0_ready = 0; resp1_ready = 1;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_req0_ready got %0b exp 1", req0_ready); end
        @(negedge clk); req0_valid = 0;
        @(negedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got %0b%0b exp 01", k, resp1_valid, resp0_valid); end
            checks++; if (resp_Result !== 32'd123) begin errors++; $display("FAIL bp_result%0d got %0d exp 123", k, resp_Result); end
            checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_req1_blocked%0d got %0b exp 0", k, req1_ready); end
            @(negedge clk); #1;
        end
        resp0_ready = 1;
        @(negedge clk); resp0_ready = 0; #1;
        checks++; if (req1_ready !== 1'b1 || resp0_valid !== 1'b0) begin errors++; $display("FAIL bp_req1_after got %0b/%0b exp 1/0", req1_ready, resp0_valid); end
        @(negedge clk); req1_valid = 0;
        @(negedge clk); #1;
        checks++; if (resp1_valid !== 1'b1 || resp_Result !== 32'd3) begin errors++; $display("FAIL bp_req1_result got %0b/%0d exp 1/3", resp1_valid, resp_Result); end
        @(negedge clk); resp1_ready = 0;
    endtask

    task automatic test_reset_mid_exec;
        apply_reset;
        req0_valid = 1; req0_A = 2; req0_B = 2; req0_ALUctr = C_ADD; resp0_ready = 1;
        @(negedge clk); req0_valid = 0;
        @(negedge clk);
        @(negedge clk);
        req0_valid = 1; req0_A = 3; req0_B = 4;
        req1_valid = 1; req1_A = 9; req1_B = 1; req1_ALUctr = C_SUB; resp1_ready = 1;
        #1;
        checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL rme_rr got %0b%0b exp 10", req1_ready, req0_ready); end
        @(negedge clk); req0_valid = 0; req1_valid = 0; #1;
        checks++; if (alu_A !== 32'd9) begin errors++; $display("FAIL rme_exec_alu got %0d exp 9", alu_A); end
        rst_n = 0; #1;
        checks++; if ({alu_A, alu_B, alu_ctr} !== 67'd0) begin errors++; $display("FAIL rme_alu_zero got %h/%h/%0d exp 0", alu_A, alu_B, alu_ctr); end
        checks++; if ({resp_Result, resp_Zero, resp_Overflow, resp0_valid, resp1_valid} !== 36'd0) begin errors++; $display("FAIL rme_resp_zero got %h/%0b/%0b/%0b/%0b exp 0", resp_Result, resp_Zero, resp_Overflow, resp0_valid, resp1_valid); end
        @(negedge clk); rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin errors++; $display("FAIL rme_no_resp%0d got %0b%0b exp 00", k, resp1_valid, resp0_valid); end
            @(negedge clk);
        end
        req0_valid = 1; req1_valid = 1; #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rme_port0_first got %0b%0b exp 01", req1_ready, req0_ready); end
        @(negedge clk); req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        @(negedge clk); resp0_ready = 0; resp1_ready = 0;
    endtask

    task automatic test_operand_change;
        apply_reset;
        req0_valid = 1; req0_A = 32'd10; req0_B = 32'd20; req0_ALUctr = C_ADD; resp0_ready = 1;
        @(negedge clk); req0_valid = 0; req0_A = 32'd999; req0_B = 32'd1; req0_ALUctr = C_SUB; #1;
        checks++; if (alu_A !== 32'd10 || alu_ctr !== C_ADD) begin errors++; $display("FAIL opchg_alu got %0d/%0d exp 10/%0d", alu_A, alu_ctr, C_ADD); end
        @(negedge clk); #1;
        checks++; if (resp0_valid !== 1'b1 || resp_Result !== 32'd30) begin errors++; $display("FAIL opchg_result got %0b/%0d exp 1/30", resp0_valid, resp_Result); end
        @(negedge clk); resp0_ready = 0;
    endtask

    // Randomized run. The model tracks one outstanding transaction: who owns it,
    // its expected result and how many edges have passed since acceptance.
    task automatic test_random;
        int          last_w, own, age;
        bit          outst, e0, e1, ev0, ev1, rh;
        logic [33:0] exp_r;
        apply_reset;
        last_w = 1; outst = 0; own = 0; age = 0; exp_r = '0;
        e0 = 0; e1 = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (e0 || !req0_valid || $urandom_range(0, 15) == 0) begin
                req0_valid  = ($urandom_range(0, 2) != 0);
                req0_A      = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
                req0_B      = ($urandom_range(0, 3) == 0) ? req0_A : $urandom;
                req0_ALUctr = 3'($urandom_range(0, 7));
            end
            if (e1 || !req1_valid || $urandom_range(0, 15) == 0) begin
                req1_valid  = ($urandom_range(0, 2) != 0);
                req1_A      = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
                req1_B      = ($urandom_range(0, 3) == 0) ? req1_A : $urandom;
                req1_ALUctr = 3'($urandom_range(0, 7));
            end
            resp0_ready = ($urandom_range(0, 3) != 0);
            resp1_ready = ($urandom_range(0, 3) != 0);
            #1;
            e0 = 0; e1 = 0;
            if (!outst) begin
                if (req0_valid && req1_valid) begin
                    e0 = (last_w == 1);
                    e1 = (last_w == 0);
                end else begin
                    e0 = req0_valid;
                    e1 = req1_valid;
                end
            end
            ev0 = outst && age >= 1 && own == 0;
            ev1 = outst && age >= 1 && own == 1;
            checks++; if (req0_ready !== e0 || req1_ready !== e1) begin errors++; $display("FAIL rnd_ready cyc %0d got %0b%0b exp %0b%0b", cyc, req1_ready, req0_ready, e1, e0); end
            checks++; if (resp0_valid !== ev0 || resp1_valid !== ev1) begin errors++; $display("FAIL rnd_resp_valid cyc %0d got %0b%0b exp %0b%0b", cyc, resp1_valid, resp0_valid, ev1, ev0); end
            if (ev0 || ev1) begin
                checks++; if ({resp_Overflow, resp_Zero, resp_Result} !== exp_r) begin errors++; $display("FAIL rnd_result cyc %0d got %0b/%0b/%h exp %0b/%0b/%h", cyc, resp_Overflow, resp_Zero, resp_Result, exp_r[33], exp_r[32], exp_r[31:0]); end
            end
            rh = (ev0 && resp0_ready) || (ev1 && resp1_ready);
            if (e0) exp_r = alu_ref(req0_A, req0_B, req0_ALUctr);
            if (e1) exp_r = alu_ref(req1_A, req1_B, req1_ALUctr);
            @(posedge clk);
            if (e0 || e1) begin
                outst = 1; age = 0; own = e1 ? 1 : 0; last_w = own;
            end else if (outst) begin
                age++;
                if (rh) outst = 0;
            end
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_single_add;
        test_round_robin;
        test_overflow;
        test_backpressure;
        test_reset_mid_exec;
        test_operand_change;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational 32-bit ALU (A, B, ALUctr in; Result, Zero, Overflow out) between two requesters, e.g. the execute stage and the address/branch unit.
- Arbitrates round-robin and registers the winning operands into the ALU.
- Captures the ALU outputs one cycle later and returns them to the winner over a valid/ready response handshake.
- Sits directly in front of the ALU instance; the ALU itself is unchanged.

Parameters:
n, 32, operand/result width (matches ALU width)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_A  input  n  operand A
req0_B  input  n  operand B
req0_ALUctr  input  3  ALU control code, passed through unchanged
resp0_valid  output  1  result for requester 0 available
resp0_ready  input  1  requester 0 consumes result
req1_valid, req1_ready, req1_A, req1_B, req1_ALUctr, resp1_valid, resp1_ready: same as requester 0
resp_Result  output  n  captured ALU Result (shared by both responses)
resp_Zero  output  1  captured ALU Zero
resp_Overflow  output  1  captured ALU Overflow
alu_A  output  n  to ALU A
alu_B  output  n  to ALU B
alu_ctr  output  3  to ALU ALUctr
alu_Result  input  n  from ALU Result
alu_Zero  input  1  from ALU Zero
alu_Overflow  input  1  from ALU Overflow

Behaviour:
- Single clock domain. rst_n asserts asynchronously and releases synchronously to clk.
- Reset values:
  - state=IDLE, last_grant=1 (port 0 wins first contention).
  - All ready/valid outputs 0.
  - alu_A, alu_B, alu_ctr = 0; resp_Result = 0, resp_Zero = 0, resp_Overflow = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant selection:
    - Exactly one valid requester: grant it.
    - Both valid: grant the port that is not last_grant.
  - reqX_ready is combinationally 1 only for the granted port (0 for both when neither is valid).
  - On valid&ready: latch that port's A/B/ALUctr into alu_A/alu_B/alu_ctr, record owner, set last_grant=owner, go to EXEC.
- EXEC (one cycle):
  - ALU evaluates the registered operands.
  - At the closing edge: capture alu_Result/alu_Zero/alu_Overflow into the resp_* registers, go to RESP.
- RESP:
  - respX_valid=1 for the owner only.
  - resp_* held stable until handshake.
  - On resp_valid&resp_ready: go to IDLE. No new request is accepted in the same cycle.
- All reqX_ready are 0 in EXEC and RESP.
- Latency: handshake edge t → resp valid from cycle t+2. Minimum issue interval 3 cycles.
- alu_A/alu_B/alu_ctr keep the last issued values outside EXEC, so no toggling occurs while idle.
- Protocol rules:
  - A requester holds valid and operands stable until ready.
  - The block samples operands only at the handshake edge, so later operand changes do not affect a latched op.
  - Deassertion of valid before handshake is tolerated; no grant is recorded.
- resp_ready from the non-owner is ignored.
- Response stalls indefinitely if the owner withholds resp_ready. The other requester waits; no timeout.
- rst_n mid-EXEC or mid-RESP discards the operation: outputs return to reset values immediately and no response is issued.
- Round-robin fairness: under continuous contention, grants alternate 0,1,0,1…

Test Plan:
1. Reset, then req0 only: A=32'h0000_0005, B=32'h0000_0003, add code → req0_ready=1 at cycle t, alu_A/alu_B valid t+1, resp0_valid at t+2 with resp_Result=8, Zero=0, Overflow=0; resp1_valid stays 0.
2. Both valid from reset: req0 A=1,B=1 and req1 A=7,B=7, subtract code, resp_ready held 1 → port 0 granted first (Result=0, Zero=1), port 1 next (Result=0, Zero=1), grant order 0,1,0,1 over 4 ops.
3. Overflow pass-through: req1 add, A=32'h7FFF_FFFF, B=1 → resp_Result=32'h8000_0000, resp_Overflow=1 on resp1.
4. Response backpressure: resp0_ready=0 for 5 cycles with req1_valid=1 → resp0_valid and resp_Result stable, req1_ready=0 throughout; req1 granted the cycle after resp0_ready=1 handshake.
5. Reset mid-EXEC: assert rst_n=0 during EXEC → all outputs 0 immediately, no resp valid after release, next request from port 0 wins.
6. Operand change after handshake: alter req0_A the cycle after acceptance → resp_Result reflects the originally latched operands.
